// File: rtl/pipe_stage_chain.sv
// -----------------------------------------------------------------------------
// pipe_stage_chain
//
// Chain of NUM_STAGES valid/data pipeline registers with per-stage stall and
// flush controls and valid/ready handshaking at both ends.
//
// Each stage moves its payload forward when it is not stalled and the stage
// in front of it can take it. A stalled stage holds its payload, sends a
// bubble forward and blocks every stage behind it. A flushed stage invalidates
// itself on the next edge. Anything that was handed to it in that cycle is
// dropped, but the sender still treats it as delivered.
//
// Parameters
//   DATA_W      payload width per stage
//   NUM_STAGES  number of chained stage registers (>= 2)
//
// Ports
//   clk          clock, all state changes on the rising edge
//   reset        asynchronous active-low reset (release synchronised outside)
//   in_valid     upstream payload valid
//   in_data      upstream payload
//   in_ready     stage 0 accepts this cycle (combinational)
//   out_valid    last stage offers its payload
//   out_data     last stage payload
//   out_ready    downstream accepts
//   stall        per-stage hold, bit i = stage i
//   flush        per-stage kill, bit i = stage i
//   stage_valid  valid bit of every stage
//   stage_data   every stage payload, stage i at [i*DATA_W +: DATA_W]
//
// Optional feature (macro PIPE_PERF_CNT_EN)
//   cnt_clr      synchronous clear of both counters, wins over increment
//   xfer_cnt     cycles with out_valid & out_ready (saturating)
//   bubble_cnt   cycles with out_ready & !out_valid (saturating)
// -----------------------------------------------------------------------------
module pipe_stage_chain #(
  parameter int DATA_W     = 32,
  parameter int NUM_STAGES = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [DATA_W-1:0]            in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [DATA_W-1:0]            out_data,
  input  logic                         out_ready,
  input  logic [NUM_STAGES-1:0]        stall,
  input  logic [NUM_STAGES-1:0]        flush,
  output logic [NUM_STAGES-1:0]        stage_valid,
  output logic [NUM_STAGES*DATA_W-1:0] stage_data
`ifdef PIPE_PERF_CNT_EN
  ,
  input  logic                         cnt_clr,
  output logic [31:0]                  xfer_cnt,
  output logic [31:0]                  bubble_cnt
`endif
);

  // Stage registers; payloads packed flat so the upstream feed of every stage
  // is just the register file shifted by one stage with in_data at the bottom.
  logic [NUM_STAGES-1:0]        valid_reg;
  logic [NUM_STAGES*DATA_W-1:0] data_reg;

  // stage_send[i]: stage i offers its payload to the next stage this cycle.
  logic [NUM_STAGES-1:0]        stage_send;
  // up_send[i] / feed_data: what stage i is being offered from behind.
  logic [NUM_STAGES-1:0]        up_send;
  logic [NUM_STAGES*DATA_W-1:0] feed_data;
  // ready_chain[i]: stage i can take a new payload; index NUM_STAGES is the
  // downstream consumer.
  logic [NUM_STAGES:0]          ready_chain;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_STAGES; gi++) begin : g_send
      // Flush suppresses the send so a killed payload never leaves the stage.
      assign stage_send[gi] = valid_reg[gi] & ~stall[gi] & ~flush[gi];
    end
  endgenerate

  assign up_send   = {stage_send[NUM_STAGES-2:0], in_valid};
  assign feed_data = {data_reg[0 +: (NUM_STAGES-1)*DATA_W], in_data};

  // Readiness ripples from the output back toward the input; flush is
  // deliberately left out so an upstream payload aimed at a flushed stage is
  // consumed (and then dropped) rather than held back.
  always_comb begin
    ready_chain             = '0;
    ready_chain[NUM_STAGES] = out_ready;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      ready_chain[i] = ~stall[i] & (~valid_reg[i] | ready_chain[i+1]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_reg <= '0;
      data_reg  <= '0;
    end else begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        if (flush[i]) begin
          // Flush beats stall and ready; payload bits are left untouched.
          valid_reg[i] <= 1'b0;
        end else if (ready_chain[i]) begin
          valid_reg[i] <= up_send[i];
          // A bubble arriving keeps the old payload bits.
          if (up_send[i]) begin
            data_reg[i*DATA_W +: DATA_W] <= feed_data[i*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  assign in_ready    = ready_chain[0];
  assign out_valid   = stage_send[NUM_STAGES-1];
  assign out_data    = data_reg[(NUM_STAGES-1)*DATA_W +: DATA_W];
  assign stage_valid = valid_reg;
  assign stage_data  = data_reg;

`ifdef PIPE_PERF_CNT_EN
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  logic [31:0] xfer_cnt_reg;
  logic [31:0] bubble_cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      xfer_cnt_reg   <= '0;
      bubble_cnt_reg <= '0;
    end else if (cnt_clr) begin
      xfer_cnt_reg   <= '0;
      bubble_cnt_reg <= '0;
    end else begin
      if (out_valid && out_ready && (xfer_cnt_reg != CNT_MAX)) begin
        xfer_cnt_reg <= xfer_cnt_reg + 32'd1;
      end
      // A bubble is a cycle where downstream was willing but nothing came out.
      if (out_ready && !out_valid && (bubble_cnt_reg != CNT_MAX)) begin
        bubble_cnt_reg <= bubble_cnt_reg + 32'd1;
      end
    end
  end

  assign xfer_cnt   = xfer_cnt_reg;
  assign bubble_cnt = bubble_cnt_reg;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_chain
//
// Self-checking bench for pipe_stage_chain. A slot-array reference model is
// stepped once per cycle from the handshake rules; every payload the model
// sees leaving the chain is queued, and an independent monitor pops that
// queue whenever the DUT presents an output transfer. Directed scenarios
// (back-to-back stream, stall, flush, back-pressure, stall+flush, reset) are
// followed by a long randomised run with a mid-stream reset.
// -----------------------------------------------------------------------------
module tb_pipe_stage_chain;

  localparam int W = 32;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic [W-1:0]   in_data;
  logic           in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_ready;
  logic [N-1:0]   stall;
  logic [N-1:0]   flush;
  logic [N-1:0]   stage_valid;
  logic [N*W-1:0] stage_data;
`ifdef PIPE_PERF_CNT_EN
  logic           cnt_clr;
  logic [31:0]    xfer_cnt;
  logic [31:0]    bubble_cnt;
  logic [31:0]    m_xfer;
  logic [31:0]    m_bubble;
`endif

  always #5 clk = ~clk;

  pipe_stage_chain #(.DATA_W(W), .NUM_STAGES(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .stall       (stall),
    .flush       (flush),
    .stage_valid (stage_valid),
    .stage_data  (stage_data)
`ifdef PIPE_PERF_CNT_EN
    ,
    .cnt_clr     (cnt_clr),
    .xfer_cnt    (xfer_cnt),
    .bubble_cnt  (bubble_cnt)
`endif
  );

  // Reference model: one slot per stage plus the ordered list of payloads
  // expected at the output.
  logic [N-1:0] m_v;
  logic [W-1:0] m_d [N];
  logic [W-1:0] exp_q [$];

  int vectors     = 0;
  int miscompares = 0;
  int cycle       = 0;
  int n_out       = 0;
  int first_in    = -1;
  int first_out   = -1;
  int last_out    = -1;
  int out_seen    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic model_reset();
    m_v = '0;
    for (int i = 0; i < N; i++) m_d[i] = '0;
    exp_q.delete();
`ifdef PIPE_PERF_CNT_EN
    m_xfer   = '0;
    m_bubble = '0;
`endif
  endtask

  task automatic clear_stats();
    n_out     = 0;
    first_in  = -1;
    first_out = -1;
    last_out  = -1;
  endtask

  // Runs at the falling edge: compare visible state and handshakes against the
  // model, then advance the model by the rising edge that follows.
  task automatic eval_cycle();
    logic [N:0]   can_take;
    logic [N-1:0] nv;
    logic [W-1:0] nd [N];
    logic         offered;
    logic [W-1:0] offer_data;
    logic         leaving;
    cycle++;

    chk("stage_valid", 64'(stage_valid), 64'(m_v));
    for (int i = 0; i < N; i++)
      chk($sformatf("stage_data[%0d]", i), 64'(stage_data[i*W +: W]), 64'(m_d[i]));

    // A slot can take a payload if it is not held and is either empty or its
    // own occupant is leaving; the consumer past the last slot is out_ready.
    can_take[N] = out_ready;
    for (int i = N - 1; i >= 0; i--)
      can_take[i] = !stall[i] && (!m_v[i] || can_take[i+1]);

    leaving = m_v[N-1] && !stall[N-1] && !flush[N-1];
    chk("in_ready", 64'(in_ready), 64'(can_take[0]));
    chk("out_valid", 64'(out_valid), 64'(leaving));
    if (leaving && out_ready) exp_q.push_back(m_d[N-1]);

    if (in_valid && in_ready && first_in < 0) first_in = cycle;
    if (out_valid && out_ready) begin
      n_out++;
      last_out = cycle;
      if (first_out < 0) first_out = cycle;
    end

`ifdef PIPE_PERF_CNT_EN
    chk("xfer_cnt", 64'(xfer_cnt), 64'(m_xfer));
    chk("bubble_cnt", 64'(bubble_cnt), 64'(m_bubble));
    if (reset) begin
      if (cnt_clr) begin
        m_xfer   = '0;
        m_bubble = '0;
      end else begin
        if (leaving && out_ready && m_xfer != 32'hFFFF_FFFF) m_xfer++;
        if (!leaving && out_ready && m_bubble != 32'hFFFF_FFFF) m_bubble++;
      end
    end
`endif

    if (!reset) return;

    for (int i = 0; i < N; i++) begin
      if (i == 0) begin
        offered    = in_valid;
        offer_data = in_data;
      end else begin
        offered    = m_v[i-1] && !stall[i-1] && !flush[i-1];
        offer_data = m_d[i-1];
      end
      nv[i] = m_v[i];
      nd[i] = m_d[i];
      if (flush[i]) begin
        nv[i] = 1'b0;
      end else if (can_take[i]) begin
        nv[i] = offered;
        if (offered) nd[i] = offer_data;
      end
    end
    m_v = nv;
    for (int i = 0; i < N; i++) m_d[i] = nd[i];
  endtask

  // One clock: check at the falling edge, return 1 time unit after the rise.
  task automatic tick();
    @(negedge clk);
    eval_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    stall     = '0;
    flush     = '0;
`ifdef PIPE_PERF_CNT_EN
    cnt_clr   = 1'b0;
`endif
  endtask

  task automatic drain(input int n);
    idle_inputs();
    repeat (n) tick();
  endtask

  task automatic async_reset_pulse();
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_stage_valid", 64'(stage_valid), 64'd0);
    chk("rst_stage_data", 64'(stage_data[63:0]), 64'd0);
`ifdef PIPE_PERF_CNT_EN
    chk("rst_xfer_cnt", 64'(xfer_cnt), 64'd0);
`endif
    repeat (2) tick();
    reset = 1'b1;
  endtask

  // Monitor: pops the expected queue whenever the DUT hands a payload out.
  initial begin
    logic [W-1:0] exp;
    forever begin
      @(negedge clk);
      #1;
      if (reset && out_valid && out_ready) begin
        out_seen++;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL out_data: got %0h, expected nothing (cycle %0d)", out_data, cycle);
        end else begin
          exp = exp_q.pop_front();
          chk("out_data", 64'(out_data), 64'(exp));
          $display("out %0d: data=%08h cycle=%0d", out_seen, out_data, cycle);
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    idle_inputs();
    model_reset();

    // In reset, in_ready simply mirrors !stall[0].
    stall = 4'b0001;
    tick();
    stall = '0;
    tick();
    reset = 1'b1;

    // Back-to-back stream 1..8: first output 4 cycles after first transfer,
    // then one output per cycle.
    clear_stats();
    for (int k = 1; k <= 8; k++) begin
      in_valid = 1'b1;
      in_data  = W'(k);
      tick();
    end
    drain(8);
    chk("latency", 64'(first_out - first_in), 64'd4);
    chk("stream_count", 64'(n_out), 64'd8);
    chk("stream_span", 64'(last_out - first_out), 64'd7);

    // Stream with stall[1] held for 3 cycles.
    clear_stats();
    for (int k = 0; k < 12; k++) begin
      in_valid = 1'b1;
      in_data  = 32'h100 + W'(k);
      stall    = (k >= 4 && k < 7) ? 4'b0010 : 4'b0000;
      tick();
    end
    drain(10);

    // Stages 0..3 = A,B,C,D with output blocked, then flush stages 0 and 1
    // while E is offered: only D then C may come out.
    clear_stats();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = 32'hD0 - W'(k * 16);
      tick();
    end
    in_valid  = 1'b1;
    in_data   = 32'hE0;
    flush     = 4'b0011;
    out_ready = 1'b1;
    tick();
    drain(6);
    chk("flush_survivors", 64'(n_out), 64'd2);

    // Full chain with out_ready low: no acceptance, then drain one per cycle.
    clear_stats();
    out_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      in_valid = 1'b1;
      in_data  = 32'h200 + W'(k);
      tick();
    end
    chk("backpressure_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (6) tick();
    chk("drain_count", 64'(n_out), 64'd4);
    chk("drain_span", 64'(last_out - first_out), 64'd3);

    // Stall and flush on stage 2 together: flush wins.
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = 32'h300 + W'(k);
      tick();
    end
    stall = 4'b0100;
    flush = 4'b0100;
    tick();
    chk("stall_flush_v2", 64'(stage_valid[2]), 64'd0);
    drain(8);

    // Randomised traffic with a reset pulse in the middle.
    for (int k = 0; k < 3000; k++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      for (int b = 0; b < N; b++) begin
        stall[b] = ($urandom_range(0, 7) == 0);
        flush[b] = ($urandom_range(0, 15) == 0);
      end
`ifdef PIPE_PERF_CNT_EN
      cnt_clr = ($urandom_range(0, 63) == 0);
`endif
      tick();
      if (k == 1500) async_reset_pulse();
    end
    drain(12);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_stage_chain.md
PIPE_STAGE_CHAIN -- requirements
Module: pipe_stage_chain

Interface
REQ-001 Parameter DATA_W, default 32, payload width per stage (instruction, operands, control packed by the instantiating block).
REQ-002 Parameter NUM_STAGES, default 4, number of chained pipeline registers (>=2).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low; clears all state immediately on assertion, release synchronised externally.
REQ-005 in_valid  input  1  upstream payload valid.
REQ-006 in_data  input  DATA_W  upstream payload.
REQ-007 in_ready  output  1  stage 0 accepts this cycle.
REQ-008 out_valid  output  1  last stage offers payload.
REQ-009 out_data  output  DATA_W  last stage payload.
REQ-010 out_ready  input  1  downstream accepts.
REQ-011 stall  input  NUM_STAGES  per-stage hold (bit i = stage i).
REQ-012 flush  input  NUM_STAGES  per-stage kill (bit i = stage i).
REQ-013 stage_valid  output  NUM_STAGES  valid bit of every stage register.
REQ-014 stage_data  output  NUM_STAGES*DATA_W  every stage register, stage i in bits [i*DATA_W +: DATA_W].

Function
REQ-015 Each stage i holds v[i] and d[i]; stage 0 fed by in_valid/in_data, stage i by stage i-1, out_* driven by stage NUM_STAGES-1.
REQ-016 send[i] = v[i] & !stall[i] & !flush[i]; send[-1] = in_valid.
REQ-017 ready[i] = !stall[i] & (!v[i] | ready[i+1]); ready[NUM_STAGES] = out_ready; in_ready = ready[0], combinational.
REQ-018 When ready[i] and !flush[i], stage i loads v[i] <= send[i-1]; d[i] <= d[i-1] only when send[i-1]=1, else d[i] holds.
REQ-019 When !ready[i] and !flush[i], v[i] and d[i] hold.
REQ-020 When flush[i]=1, v[i] <= 0 next edge regardless of stall/ready; d[i] holds; any payload transferred into stage i that cycle is discarded while upstream still sees it consumed.
REQ-021 Flush wins over stall on the same stage in the same cycle.
REQ-022 out_valid = send[NUM_STAGES-1]; out_data = d[NUM_STAGES-1].
REQ-023 Stalled stage i emits a bubble into stage i+1 (if i+1 ready) and back-pressures all stages below it.
REQ-024 Latency: NUM_STAGES cycles from in transfer (in_valid&in_ready) to out_valid with no stall/flush; throughput 1 payload/cycle.
REQ-025 No payload is duplicated or lost except by flush; order is preserved.

Reset
REQ-026 On reset low: all v[i]=0, all d[i]=0, out_valid=0, out_data=0, stage_valid=0, stage_data=0, counters (if present)=0.
REQ-027 In reset and first cycle after release, in_ready = !stall[0].
REQ-028 Reset asserted mid-operation drops all in-flight payloads; no out_valid until new input traverses all stages.

Configuration
REQ-029 Macro PIPE_PERF_CNT_EN: when defined, adds inputs cnt_clr (1) and outputs xfer_cnt (32), bubble_cnt (32).
REQ-030 With PIPE_PERF_CNT_EN: xfer_cnt +1 per cycle with out_valid&out_ready; bubble_cnt +1 per cycle with out_ready&!out_valid; both saturate at 32'hFFFFFFFF; synchronous cnt_clr zeroes both, overriding increment.
REQ-031 Without PIPE_PERF_CNT_EN: ports and counter logic absent; all other behaviour identical.

Verification
REQ-032 Defaults, stall=0, flush=0, out_ready=1, feed 32'h1..32'h8 back-to-back -> out_data 1..8 on consecutive cycles, first out_valid 4 cycles after first transfer.
REQ-033 Stream running, stall[1]=1 for 3 cycles -> stage 2 receives 3 bubbles, in_ready=0 once stage 0 full, no payload lost or duplicated, order intact.
REQ-034 Stages 0..3 holding A,B,C,D, flush=4'b0011 one cycle -> A and B never appear at output, C,D emerge; in_data offered that cycle also discarded.
REQ-035 out_ready=0 with 4 valid payloads -> in_ready=0, stage_data stable; out_ready=1 -> drain one per cycle.
REQ-036 stall[2]=1 and flush[2]=1 same cycle -> stage_valid[2]=0 next cycle.
REQ-037 Reset pulsed low mid-stream -> outputs zero immediately (asynchronously); with PIPE_PERF_CNT_EN, counters 0, 5 transfers -> xfer_cnt=5, cnt_clr -> 0.
